fir_output_stage: RTL and testbench

Output conditioner sitting directly downstream of the last systolic FIR tap: takes the raw accumulator word from the end of the tap chain and discards chain warm-up samples. It applies programmable decimation, rounds and saturates to the output width, and buffers results in a 2-entry FIFO with valid/ready handshake. Overrun and saturation events are latched in sticky status flags for the register interface.

---
 rtl/fir_pkg.sv | 40 ++++
 rtl/fir_output_stage_if.sv | 13 +
 rtl/fir_out_fifo2.sv | 49 ++++
 rtl/fir_output_stage.sv | 126 ++++++++++++
 tb/tb_fir_output_stage.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fir_pkg.sv
// Shared FIR width-reduction helpers: default widths plus round-half-up and saturate.
// Arithmetic runs in a 64-bit signed working width, which covers any accumulator up to 63 bits.
package fir_pkg;
    localparam int ACCW_DEF  = 48;
    localparam int OUTW_DEF  = 16;
    localparam int COEFW_DEF = 18;
    localparam int CALCW     = 64;

    function automatic logic signed [CALCW-1:0] round_half_up(
        input logic signed [CALCW-1:0] x,
        input int                      shift
    );
        logic signed [CALCW-1:0] half;
        half = 64'sd1 <<< (shift - 1);
        return (x + half) >>> shift;
    endfunction

    function automatic logic signed [CALCW-1:0] sat_max(input int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [CALCW-1:0] sat_min(input int w);
        return -(64'sd1 <<< (w - 1));
    endfunction

    function automatic logic sat_hit(input logic signed [CALCW-1:0] x, input int w);
        return (x > sat_max(w)) || (x < sat_min(w));
    endfunction

    function automatic logic signed [CALCW-1:0] saturate(input logic signed [CALCW-1:0] x, input int w);
        logic signed [CALCW-1:0] y;
        y = x;
        if (x > sat_max(w)) begin
            y = sat_max(w);
        end else if (x < sat_min(w)) begin
            y = sat_min(w);
        end
        return y;
    endfunction
endpackage

// File: rtl/fir_output_stage_if.sv
// Output sample stream of the FIR output stage: data with valid/ready handshake.
interface fir_output_stage_if
    import fir_pkg::*;
#(
    parameter int OUTW = OUTW_DEF
);
    logic signed [OUTW-1:0] out_data;
    logic                   out_valid;
    logic                   out_ready;

    modport master (output out_data, output out_valid, input out_ready);
    modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/fir_out_fifo2.sv
// Two-entry synchronous FIFO; a push while full only lands if a pop frees the slot that cycle.
module fir_out_fifo2 #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         pop_i,
    output logic [W-1:0] data_o,
    output logic         full_o,
    output logic         empty_o
);
    logic [W-1:0] mem_q [2];
    logic         wr_ptr_q;
    logic         rd_ptr_q;
    logic [1:0]   cnt_q;
    logic         do_push;
    logic         do_pop;

    assign empty_o = (cnt_q == 2'd0);
    assign full_o  = (cnt_q == 2'd2);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign data_o  = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (!reset) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 2'd1;
                2'b01:   cnt_q <= cnt_q - 2'd1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end
endmodule

// File: rtl/fir_output_stage.sv
// FIR output conditioner: warm-up discard, decimation, round/saturate pipeline and output FIFO.
// Sticky saturation/overrun flags are exported for the register interface.
module fir_output_stage
    import fir_pkg::*;
#(
    parameter int ACCW  = ACCW_DEF,
    parameter int OUTW  = OUTW_DEF,
    parameter int SHIFT = 17,
    parameter int FILL  = 34
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic signed [ACCW-1:0] acc_in,
    input  logic                   acc_valid,
    input  logic                   restart,
    input  logic [7:0]             decim,
    fir_output_stage_if.master     out_if,
    output logic                   sat_flag,
    output logic                   ovr_flag,
    input  logic                   clr_flags
);
    localparam int RW  = ACCW + 1;
    localparam int WCW = $clog2(FILL + 1);

    logic [WCW-1:0]         wcnt_q, wcnt_d;
    logic [7:0]             phase_q, phase_d;
    logic                   s1_vld_q, s1_vld_d;
    logic signed [RW-1:0]   s1_rnd_q;
    logic                   s2_vld_q, s2_vld_d;
    logic                   s2_sat_q;
    logic signed [OUTW-1:0] s2_dat_q;
    logic                   sat_q, sat_d;
    logic                   ovr_q, ovr_d;

    logic                   warm;
    logic                   keep;
    logic [8:0]             decim_eff;
    logic signed [CALCW-1:0] acc_ext;
    logic signed [CALCW-1:0] s1_ext;
    logic signed [CALCW-1:0] sat_val;
    logic signed [RW-1:0]   rnd_full;
    logic                   push;
    logic                   pop;
    logic                   drop;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [OUTW-1:0]        fifo_data;

    always_comb begin
        acc_ext   = {{(CALCW-ACCW){acc_in[ACCW-1]}}, acc_in};
        s1_ext    = {{(CALCW-RW){s1_rnd_q[RW-1]}}, s1_rnd_q};
        rnd_full  = RW'(round_half_up(acc_ext, SHIFT));
        sat_val   = saturate(s1_ext, OUTW);
        warm      = (wcnt_q < WCW'(FILL));
        decim_eff = (decim == 8'd0) ? 9'd1 : {1'b0, decim};
        keep      = acc_valid && !warm && (phase_q == 8'd0);

        wcnt_d  = wcnt_q;
        phase_d = phase_q;
        if (restart) begin
            wcnt_d  = '0;
            phase_d = '0;
        end else if (acc_valid) begin
            if (warm) begin
                wcnt_d = wcnt_q + WCW'(1);
            end else begin
                // A phase left beyond a newly lowered factor wraps on its next step.
                phase_d = (({1'b0, phase_q} + 9'd1) >= decim_eff) ? 8'd0 : phase_q + 8'd1;
            end
        end

        s1_vld_d = keep && !restart;
        s2_vld_d = s1_vld_q && !restart;

        push = s2_vld_q && !restart;
        pop  = out_if.out_valid && out_if.out_ready;
        drop = push && fifo_full && !pop;

        sat_d = (push && s2_sat_q) ? 1'b1 : (clr_flags ? 1'b0 : sat_q);
        ovr_d = drop ? 1'b1 : (clr_flags ? 1'b0 : ovr_q);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wcnt_q   <= '0;
            phase_q  <= '0;
            s1_vld_q <= 1'b0;
            s1_rnd_q <= '0;
            s2_vld_q <= 1'b0;
            s2_sat_q <= 1'b0;
            s2_dat_q <= '0;
            sat_q    <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            wcnt_q   <= wcnt_d;
            phase_q  <= phase_d;
            s1_vld_q <= s1_vld_d;
            if (keep) begin
                s1_rnd_q <= rnd_full;
            end
            s2_vld_q <= s2_vld_d;
            s2_sat_q <= sat_hit(s1_ext, OUTW);
            s2_dat_q <= OUTW'(sat_val);
            sat_q    <= sat_d;
            ovr_q    <= ovr_d;
        end
    end

    fir_out_fifo2 #(
        .W (OUTW)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .data_i  (s2_dat_q),
        .pop_i   (pop),
        .data_o  (fifo_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign out_if.out_data  = fifo_data;
    assign out_if.out_valid = !fifo_empty;
    assign sat_flag         = sat_q;
    assign ovr_flag         = ovr_q;
endmodule

// File: tb/tb_fir_output_stage.sv
// Bench for fir_output_stage: directed vector table and sequences, then random traffic
// checked every cycle against a queue-based reference model.
`timescale 1ns/1ps
module tb_fir_output_stage;
    localparam int ACCW  = 48;
    localparam int OUTW  = 16;
    localparam int SHIFT = 17;
    localparam int FILL  = 34;

    logic                   clk = 1'b0;
    logic                   reset = 1'b0;
    logic signed [ACCW-1:0] acc_in = '0;
    logic                   acc_valid = 1'b0;
    logic                   restart = 1'b0;
    logic [7:0]             decim = 8'd1;
    logic                   clr_flags = 1'b0;
    logic                   sat_flag;
    logic                   ovr_flag;

    fir_output_stage_if #(.OUTW(OUTW)) oif();

    fir_output_stage #(
        .ACCW(ACCW), .OUTW(OUTW), .SHIFT(SHIFT), .FILL(FILL)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .acc_in    (acc_in),
        .acc_valid (acc_valid),
        .restart   (restart),
        .decim     (decim),
        .out_if    (oif),
        .sat_flag  (sat_flag),
        .ovr_flag  (ovr_flag),
        .clr_flags (clr_flags)
    );

    always #5 clk = ~clk;

    typedef struct { int due; int val; bit sat; } pend_t;
    typedef struct { longint acc; int exp; bit sat; } vec_t;

    pend_t  pend[$];
    int     mq[$];
    int     got[$];
    int     m_wcnt, m_p, cyc;
    bit     m_sat, m_ovr;
    int     n_vec, n_err;

    // Spec arithmetic: floor((acc + half) / 2^SHIFT), then clamp to the output range.
    function automatic int ref_sample(input longint a, output bit sat);
        longint num, q, dv, hi, lo;
        dv  = longint'(1) <<< SHIFT;
        num = a + (dv / 2);
        q   = num / dv;
        if (num < 0 && (num % dv) != 0) q = q - 1;
        hi  = (longint'(1) <<< (OUTW - 1)) - 1;
        lo  = -(longint'(1) <<< (OUTW - 1));
        sat = 1'b0;
        if (q > hi) begin sat = 1'b1; q = hi; end
        if (q < lo) begin sat = 1'b1; q = lo; end
        return int'(q);
    endfunction

    task automatic model_edge();
        pend_t e;
        bit pop, do_push, set_sat, set_ovr, s;
        int d, v;
        cyc++;
        if (!reset) begin
            pend.delete(); mq.delete();
            m_wcnt = 0; m_p = 0; m_sat = 0; m_ovr = 0;
            return;
        end
        pop = (mq.size() > 0) && oif.out_ready;
        do_push = 0; set_sat = 0; set_ovr = 0;
        if (restart) pend.delete();
        else if (pend.size() > 0 && pend[0].due == cyc) begin
            e = pend.pop_front();
            set_sat = e.sat;
            if (mq.size() < 2 || pop) do_push = 1;
            else set_ovr = 1;
        end
        if (pop) void'(mq.pop_front());
        if (do_push) mq.push_back(e.val);
        m_sat = set_sat ? 1'b1 : (clr_flags ? 1'b0 : m_sat);
        m_ovr = set_ovr ? 1'b1 : (clr_flags ? 1'b0 : m_ovr);
        if (restart) begin
            m_wcnt = 0; m_p = 0;
        end else if (acc_valid) begin
            if (m_wcnt < FILL) m_wcnt++;
            else begin
                d = (decim == 0) ? 1 : int'(decim);
                if (m_p == 0) begin
                    v = ref_sample(longint'(acc_in), s);
                    pend.push_back('{cyc + 2, v, s});
                end
                m_p = (m_p + 1 >= d) ? 0 : m_p + 1;
            end
        end
    endtask

    task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        if (oif.out_valid === 1'b1 && oif.out_ready === 1'b1) got.push_back(int'(oif.out_data));
        @(posedge clk);
        model_edge();
        #1;
        check("model_out_valid", 64'(oif.out_valid), 64'(mq.size() > 0));
        if (mq.size() > 0) check("model_out_data", 64'(oif.out_data), 64'(mq[0]));
        check("model_sat_flag", 64'(sat_flag), 64'(m_sat));
        check("model_ovr_flag", 64'(ovr_flag), 64'(m_ovr));
    endtask

    task automatic idle(input int n);
        acc_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic feed(input longint v);
        acc_in = v[ACCW-1:0];
        acc_valid = 1'b1;
        tick();
    endtask

    task automatic rewarm();
        restart = 1'b1; acc_valid = 1'b1; acc_in = '1;
        tick();
        restart = 1'b0;
        for (int i = 0; i < FILL; i++) feed(longint'(7777) * 131072);
        acc_valid = 1'b0;
    endtask

    function automatic longint rand_acc();
        longint v;
        case ($urandom_range(0, 3))
            0: v = longint'($signed($urandom));
            1: v = longint'($signed($urandom)) * 4;
            2: v = {$urandom, $urandom};
            default: v = (longint'($urandom_range(0, 65535)) - 32768) * 131072
                         + longint'($urandom_range(0, 131071)) - 65536;
        endcase
        return v;
    endfunction

    vec_t tbl[12];
    int   first_k;

    initial begin
        n_vec = 0; n_err = 0; cyc = 0;
        tbl = '{
            '{64'sd196608,           2,      1'b0},
            '{-64'sd196608,          -1,     1'b0},
            '{64'sd65535,            0,      1'b0},
            '{64'sd65536,            1,      1'b0},
            '{-64'sd65536,           0,      1'b0},
            '{-64'sd65537,           -1,     1'b0},
            '{64'sd1099511627776,    32767,  1'b1},
            '{-64'sd1099511627776,   -32768, 1'b1},
            '{64'sd4294836224,       32767,  1'b0},
            '{64'sd4294967296,       32767,  1'b1},
            '{-64'sd4294967296,      -32768, 1'b0},
            '{-64'sd4295098368,      -32768, 1'b1}
        };

        oif.out_ready = 1'b0;
        reset = 1'b0;
        repeat (3) tick();
        check("rst_out_valid", 64'(oif.out_valid), 0);
        check("rst_out_data", 64'(oif.out_data), 0);
        check("rst_sat", 64'(sat_flag), 0);
        check("rst_ovr", 64'(ovr_flag), 0);

        // Warm-up and latency from reset release
        oif.out_ready = 1'b1; decim = 8'd1; reset = 1'b1;
        first_k = -1; got.delete();
        for (int k = 0; k < 46; k++) begin
            feed(longint'(k) * 131072);
            if (first_k < 0 && oif.out_valid === 1'b1) first_k = k;
        end
        check("first_valid_cycle", first_k, 36);
        check("warm_count", got.size(), 9);
        foreach (got[j]) check("warm_data", got[j], 34 + j);
        idle(4);

        // Rounding / saturation vector table
        foreach (tbl[i]) begin
            acc_in = tbl[i].acc[ACCW-1:0]; acc_valid = 1'b1; clr_flags = 1'b1;
            tick();
            acc_valid = 1'b0; clr_flags = 1'b0;
            tick(); tick();
            check("tbl_valid", 64'(oif.out_valid), 1);
            check("tbl_data", 64'(oif.out_data), 64'(tbl[i].exp));
            check("tbl_sat", 64'(sat_flag), 64'(tbl[i].sat));
            tick();
        end

        // Set beats clear in the same cycle
        clr_flags = 1'b1; feed(longint'(1) <<< 40);
        clr_flags = 1'b0; idle(1);
        clr_flags = 1'b1; idle(1);
        check("sat_set_wins", 64'(sat_flag), 1);
        idle(1);
        check("sat_cleared", 64'(sat_flag), 0);
        clr_flags = 1'b0; idle(3);

        // Decimation by 4
        decim = 8'd4; rewarm(); got.delete();
        for (int j = 0; j < 16; j++) feed(longint'(j) * 131072);
        idle(5);
        check("dec4_count", got.size(), 4);
        foreach (got[j]) check("dec4_data", got[j], 4 * j);

        // Decimation 0 acts as 1
        decim = 8'd0; rewarm(); got.delete();
        for (int j = 0; j < 5; j++) feed(longint'(50 + j) * 131072);
        idle(5);
        check("dec0_count", got.size(), 5);
        foreach (got[j]) check("dec0_data", got[j], 50 + j);

        // Backpressure and overrun
        decim = 8'd1; clr_flags = 1'b1; idle(1); clr_flags = 1'b0;
        oif.out_ready = 1'b0;
        for (int j = 0; j < 4; j++) feed(longint'(100 + j) * 131072);
        check("ovr_before_third", 64'(ovr_flag), 0);
        idle(1);
        check("ovr_at_third", 64'(ovr_flag), 1);
        idle(3);
        check("bp_head", 64'(oif.out_data), 100);
        got.delete(); oif.out_ready = 1'b1;
        idle(4);
        check("bp_count", got.size(), 2);
        foreach (got[j]) check("bp_data", got[j], 100 + j);

        // Restart with two samples in flight
        clr_flags = 1'b1; idle(1); clr_flags = 1'b0;
        oif.out_ready = 1'b0; got.delete();
        feed(longint'(200) * 131072);
        idle(3);
        feed(longint'(201) * 131072);
        feed(longint'(202) * 131072);
        restart = 1'b1; feed(longint'(203) * 131072); restart = 1'b0;
        check("rst_keep_valid", 64'(oif.out_valid), 1);
        check("rst_keep_data", 64'(oif.out_data), 200);
        oif.out_ready = 1'b1;
        for (int j = 0; j < 36; j++) feed(longint'(300 + j) * 131072);
        idle(5);
        check("restart_count", got.size(), 3);
        if (got.size() == 3) begin
            check("restart_d0", got[0], 200);
            check("restart_d1", got[1], 334);
            check("restart_d2", got[2], 335);
        end

        // Reset mid-stream
        oif.out_ready = 1'b0;
        feed(longint'(1) <<< 40); feed(64'sd131072); feed(64'sd262144);
        idle(3);
        reset = 1'b0; idle(1);
        check("midrst_valid", 64'(oif.out_valid), 0);
        check("midrst_sat", 64'(sat_flag), 0);
        check("midrst_ovr", 64'(ovr_flag), 0);
        reset = 1'b1;

        // Random traffic against the reference model
        for (int c = 0; c < 4000; c++) begin
            acc_valid     = ($urandom_range(0, 3) != 0);
            acc_in        = rand_acc();
            oif.out_ready = ($urandom_range(0, 9) < 7);
            restart       = ($urandom_range(0, 199) == 0);
            clr_flags     = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 49) == 0) decim = 8'($urandom_range(0, 5));
            tick();
        end
        restart = 1'b0; clr_flags = 1'b0; oif.out_ready = 1'b1;
        idle(6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
